// File: rtl/bram_wbslave_pkg.sv
// Conbus-wide Wishbone constants and the bram_wbslave FSM encoding.
package bram_wbslave_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INC     = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CLASSIC = 2'd1,
    ST_BURST   = 2'd2
  } state_t;

endpackage

// File: rtl/bram_wbslave_mem.sv
// Read-first synchronous RAM with 4 byte lanes.
// Separate write/read addresses so the top can prefetch during bursts.
module bram_wbslave_mem #(
  parameter int aw   = 11,
  parameter     init = ""
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [aw-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [aw-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [0:(1<<aw)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      if (sel[0]) mem[waddr][7:0]   <= wdata[7:0];
      if (sel[1]) mem[waddr][15:8]  <= wdata[15:8];
      if (sel[2]) mem[waddr][23:16] <= wdata[23:16];
      if (sel[3]) mem[waddr][31:24] <= wdata[31:24];
    end
  end

  // Output register reset only; array contents survive sys_rst.
  always_ff @(posedge clk) begin
    if (rst) rdata <= '0;
    else     rdata <= mem[raddr];
  end

endmodule

// File: rtl/bram_wbslave.sv
// Wishbone B3 block-RAM slave with classic cycles and CTI incrementing bursts.
// Define BRAM_WBSLAVE_BURST_EN for 1 word/clock bursts; otherwise every beat is classic.
import bram_wbslave_pkg::*;

module bram_wbslave #(
  parameter int adr_width = 11,
  parameter     init      = ""
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [2:0]  wb_cti_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic        wb_ack_o
);

  state_t                 state, state_n;
  logic                   ack_n;
  logic                   req;
  logic [adr_width-1:0]   wadr, radr;

  assign req  = wb_cyc_i & wb_stb_i;
  assign wadr = wb_adr_i[adr_width+1:2];

`ifdef BRAM_WBSLAVE_BURST_EN
  // Prefetch the next word while a burst continues; wraps modulo depth.
  assign radr = (state == ST_BURST && wb_ack_o && wb_cti_i == CTI_INC)
              ? wadr + adr_width'(1) : wadr;
`else
  assign radr = wadr;
`endif

  logic unused_ok;
`ifdef BRAM_WBSLAVE_BURST_EN
  assign unused_ok = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0]};
`else
  assign unused_ok = ^{wb_adr_i[31:adr_width+2], wb_adr_i[1:0], wb_cti_i};
`endif

  bram_wbslave_mem #(
    .aw   (adr_width),
    .init (init)
  ) u_mem (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .we    (req & wb_we_i & ~sys_rst),
    .sel   (wb_sel_i),
    .waddr (wadr),
    .wdata (wb_dat_i),
    .raddr (radr),
    .rdata (wb_dat_o)
  );

  always_comb begin
    state_n = state;
    ack_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req) begin
          ack_n = 1'b1;
`ifdef BRAM_WBSLAVE_BURST_EN
          state_n = (wb_cti_i == CTI_INC) ? ST_BURST : ST_CLASSIC;
`else
          state_n = ST_CLASSIC;
`endif
        end
      end
      ST_CLASSIC: state_n = ST_IDLE;
`ifdef BRAM_WBSLAVE_BURST_EN
      // End-of-burst, master wait and cycle drop all fall back to IDLE.
      ST_BURST: begin
        if (req && wb_cti_i == CTI_INC) ack_n = 1'b1;
        else                            state_n = ST_IDLE;
      end
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= ST_IDLE;
      wb_ack_o <= 1'b0;
    end else begin
      state    <= state_n;
      wb_ack_o <= ack_n;
    end
  end

endmodule

// File: tb/tb_bram_wbslave.sv
// Directed self-checking bench for bram_wbslave (adr_width = 4, 16 words).
module tb_bram_wbslave;

  localparam int AW = 4;
  localparam int unsigned MASK = (1 << AW) - 1;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [2:0]  wb_cti_i;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i, wb_ack_o;

  always #5 sys_clk = ~sys_clk;

  bram_wbslave #(.adr_width(AW)) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_dat_o (wb_dat_o),
    .wb_cti_i (wb_cti_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_ack_o (wb_ack_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] wdat [8];
  logic [31:0] rdat [8];
  logic [31:0] pat;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_bus();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = 3'b000; wb_sel_i = 4'h0; wb_adr_i = '0; wb_dat_i = '0;
  endtask

  task automatic sync();
    @(posedge sys_clk); #1;
  endtask

  // Classic transfer; lat counts ack-low cycles before the ack.
  task automatic single(input string tag, input int unsigned word, input logic we,
                        input logic [31:0] d, input logic [3:0] sel,
                        output logic [31:0] q, output int unsigned lat);
    logic seen = 1'b0;
    lat = 0; q = '0;
    wb_adr_i = 32'((word & MASK) << 2);
    wb_dat_i = d; wb_sel_i = sel; wb_we_i = we; wb_cti_i = 3'b000;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    while (!seen && lat < 8) begin
      @(negedge sys_clk);
      if (wb_ack_o) begin seen = 1'b1; q = wb_dat_o; end
      else lat++;
    end
    check({tag, "_ack"}, 32'(seen), 32'd1);
    sync();
    idle_bus();
  endtask

  task automatic wr(input int unsigned word, input logic [31:0] d);
    logic [31:0] q; int unsigned lat;
    single("pre", word, 1'b1, d, 4'hF, q, lat);
  endtask

  task automatic rd(input string tag, input int unsigned word, input logic [31:0] exp);
    logic [31:0] q; int unsigned lat;
    single(tag, word, 1'b0, '0, 4'hF, q, lat);
    check(tag, q, exp);
  endtask

  task automatic drive_beat(input int unsigned start, input int unsigned beat,
                            input int unsigned n, input logic we);
    wb_adr_i = 32'(((start + beat) & MASK) << 2);
    wb_cti_i = (beat == n - 1) ? 3'b111 : 3'b010;
    wb_dat_i = wdat[beat];
    wb_we_i  = we; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
  endtask

  // Incrementing burst; address advances at the edge after each ack.
  // rst_at != 0 raises sys_rst during the cycle carrying that acked beat.
  task automatic burst(input string tag, input int unsigned start, input int unsigned n,
                       input logic we, input int unsigned rst_at);
    int unsigned beat = 0, cycles = 0;
    logic hit_rst = 1'b0;
    pat = '0;
    drive_beat(start, 0, n, we);
    while (beat < n && cycles < 40 && !hit_rst) begin
      @(negedge sys_clk);
      cycles++;
      pat = {pat[30:0], wb_ack_o};
      if (wb_ack_o) begin
        rdat[beat] = wb_dat_o;
        beat++;
        if (rst_at != 0 && beat == rst_at) begin
          sys_rst = 1'b1; hit_rst = 1'b1;
        end
      end
      if (beat < n && !hit_rst) begin
        sync();
        drive_beat(start, beat, n, we);
      end
    end
    check({tag, "_beats"}, 32'(beat), 32'((rst_at != 0) ? rst_at : n));
    sync();
    sys_rst = 1'b0;
    idle_bus();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] q;
    int unsigned lat;

    idle_bus();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check("rst_ack", 32'(wb_ack_o), 32'd0);
    check("rst_dat", wb_dat_o, 32'd0);
    sync();
    sys_rst = 1'b0;
    sync();

    wr(5, 32'hDEADBEEF);
    wr(3, 32'h11223344);
    wr(8, 32'd1); wr(9, 32'd2); wr(10, 32'd3); wr(11, 32'd4);
    wr(15, 32'h0000_0F15); wr(0, 32'h0000_0F00); wr(1, 32'h0000_0F01);
    wr(12, 32'h0000_1212); wr(13, 32'h0000_1313);

    // Classic read: 1-cycle latency, ack for one cycle only
    single("cl_rd", 5, 1'b0, '0, 4'hF, q, lat);
    check("cl_rd_data", q, 32'hDEADBEEF);
    check("cl_rd_lat", 32'(lat), 32'd1);
    @(negedge sys_clk);
    check("cl_rd_acklow", 32'(wb_ack_o), 32'd0);
    sync();

    // Byte-lane write
    single("bw", 3, 1'b1, 32'hAABBCCDD, 4'b0101, q, lat);
    rd("bw_rb", 3, 32'h11BB33DD);

    // 4-beat burst read
    burst("br", 8, 4, 1'b0, 0);
`ifdef BRAM_WBSLAVE_BURST_EN
    check("br_pat", pat, 32'b01111);
`else
    check("br_pat", pat, 32'b01010101);
`endif
    for (int i = 0; i < 4; i++) check("br_data", rdat[i], 32'(i + 1));
    @(negedge sys_clk);
    check("br_tail", 32'(wb_ack_o), 32'd0);
    sync();

    // Burst across the top word
    burst("wr", 15, 3, 1'b0, 0);
`ifdef BRAM_WBSLAVE_BURST_EN
    check("wrap_pat", pat, 32'b0111);
`else
    check("wrap_pat", pat, 32'b010101);
`endif
    check("wrap_d0", rdat[0], 32'h0000_0F15);
    check("wrap_d1", rdat[1], 32'h0000_0F00);
    check("wrap_d2", rdat[2], 32'h0000_0F01);
    @(negedge sys_clk);
    check("wrap_tail", 32'(wb_ack_o), 32'd0);
    sync();

    // Reset on the 2nd acked beat of a write burst
    wdat[0] = 32'hC0DE000C;
    wdat[1] = 32'hC0DE000D;
    burst("rb", 12, 2, 1'b1, 2);
    @(negedge sys_clk);
    check("rb_ack", 32'(wb_ack_o), 32'd0);
    check("rb_dat", wb_dat_o, 32'd0);
    sync();
    rd("rb_w12", 12, 32'hC0DE000C);
`ifdef BRAM_WBSLAVE_BURST_EN
    rd("rb_w13", 13, 32'h0000_1313);
`else
    rd("rb_w13", 13, 32'hC0DE000D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
